// File: rtl/fifo_pkg.sv
// Shared FIFO defaults plus the elaboration-time helpers for sizing and
// level-range checks.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_FIFO_DEPTH   = 16;
  localparam int unsigned DEF_FIFO_C_WIDTH = 4;
  localparam int unsigned DEF_AF_LEVEL     = 12;
  localparam int unsigned DEF_AE_LEVEL     = 2;

  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width = width + 1;
    return width;
  endfunction

  function automatic bit level_in_range(input int unsigned level,
                                        input int unsigned lo,
                                        input int unsigned hi);
    return (level >= lo) && (level <= hi);
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module fifo_ram_dp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, registered status flags,
// sticky error bits, flush, and FWFT or registered read data path.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned FIFO_C_WIDTH = DEF_FIFO_C_WIDTH,
  parameter int unsigned AF_LEVEL     = DEF_AF_LEVEL,
  parameter int unsigned AE_LEVEL     = DEF_AE_LEVEL,
  parameter int unsigned FWFT         = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    clr_err,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [FIFO_C_WIDTH:0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned PW = FIFO_C_WIDTH + 1;
  localparam logic [PW-1:0] ONE    = PW'(1);
  localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

  if ((FIFO_DEPTH < 4) || (log2_ceil(FIFO_DEPTH) != FIFO_C_WIDTH) ||
      ((64'd1 << FIFO_C_WIDTH) != 64'(FIFO_DEPTH))) begin : g_bad_depth
    $error("sync_fifo_ctrl: FIFO_DEPTH must be 2**FIFO_C_WIDTH and >= 4");
  end
  if (!level_in_range(AF_LEVEL, 1, FIFO_DEPTH) ||
      !level_in_range(AE_LEVEL, 0, FIFO_DEPTH - 1)) begin : g_bad_level
    $error("sync_fifo_ctrl: AF_LEVEL/AE_LEVEL out of range");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  afull_q, afull_d, aempty_q, aempty_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, ram_rdata;
  logic                  wr_acc, rd_acc;

  fifo_ram_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (FIFO_C_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[FIFO_C_WIDTH-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[FIFO_C_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    // flush masks both requests, so it can neither move data nor raise errors
    wr_acc     = wr_en & ~full_q & ~flush;
    rd_acc     = rd_en & ~empty_q & ~flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = (ovf_q & ~clr_err) | (wr_en & full_q & ~flush);
    unf_d      = (unf_q & ~clr_err) | (rd_en & empty_q & ~flush);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + ONE;
        rd_data_d  = ram_rdata;
        rd_valid_d = 1'b1;
      end
      if (wr_acc && !rd_acc)      count_d = count_q + ONE;
      else if (rd_acc && !wr_acc) count_d = count_q - ONE;
    end

    full_d   = (wr_ptr_d[FIFO_C_WIDTH-1:0] == rd_ptr_d[FIFO_C_WIDTH-1:0]) &&
               (wr_ptr_d[FIFO_C_WIDTH] != rd_ptr_d[FIFO_C_WIDTH]);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    afull_d  = (count_d >= AF_CNT);
    aempty_d = (count_d <= AE_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // FWFT output is forced to zero while empty so reset shows rd_data = 0
  assign rd_data      = (FWFT != 0) ? (empty_q ? '0 : ram_rdata) : rd_data_q;
  assign rd_valid     = (FWFT != 0) ? ~empty_q : rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: FWFT and registered-read builds driven in lockstep
// and compared against a queue-based reference model.
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst, flush, clr_err, wr_en, rd_en;
  logic [7:0] wr_data;

  logic [7:0] f_rd_data, r_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic       r_rd_valid, r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
  logic [4:0] f_count, r_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_rv0;
  logic [7:0] m_rd0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .FIFO_C_WIDTH(4),
    .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .FIFO_C_WIDTH(4),
    .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(0)
  ) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(r_rd_data), .rd_valid(r_rd_valid), .full(r_full), .empty(r_empty),
    .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
    .overflow(r_ovf), .underflow(r_unf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rv0 = 1'b0;
    m_rd0 = 8'h00;
  endtask

  task automatic model_step(input bit w, input logic [7:0] d, input bit r,
                            input bit f, input bit c);
    bit full_p, empty_p;
    full_p  = (q.size() == DEPTH);
    empty_p = (q.size() == 0);
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    m_rv0 = 1'b0;
    if (f) begin
      q.delete();
    end else begin
      if (w && full_p)  m_ovf = 1'b1;
      if (r && empty_p) m_unf = 1'b1;
      if (r && !empty_p) begin
        m_rd0 = q.pop_front();
        m_rv0 = 1'b1;
      end
      if (w && !full_p) q.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"},  f_count, n);
    chk({tag, ".empty"},  f_empty, n == 0);
    chk({tag, ".full"},   f_full,  n == DEPTH);
    chk({tag, ".afull"},  f_af,    n >= AF);
    chk({tag, ".aempty"}, f_ae,    n <= AE);
    chk({tag, ".ovf"},    f_ovf,   m_ovf);
    chk({tag, ".unf"},    f_unf,   m_unf);
    chk({tag, ".r_count"}, r_count, n);
    chk({tag, ".r_flags"}, {r_full, r_empty, r_af, r_ae, r_ovf, r_unf},
        {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_unf});
    chk({tag, ".f_valid"}, f_rd_valid, n != 0);
    if (n != 0) chk({tag, ".f_data"}, f_rd_data, q[0]);
    chk({tag, ".r_valid"}, r_rd_valid, m_rv0);
    chk({tag, ".r_data"},  r_rd_data,  m_rd0);
  endtask

  task automatic cycle(input string tag, input bit w, input logic [7:0] d, input bit r,
                       input bit f = 1'b0, input bit c = 1'b0);
    wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c;
    @(posedge clk);
    #1;
    model_step(w, d, r, f, c);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, ".f_data0"}, f_rd_data, 8'h00);
    chk({tag, ".r_data0"}, r_rd_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         w;
    logic [7:0] d;
    bit         r, f, c;
    int         ecnt;
    bit         eempty, eovf, eunf;
    logic [7:0] erd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    rst = 1'b1; flush = 1'b0; clr_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // directed vectors from the reset state
    tbl[0]  = '{1, 8'hA1, 0, 0, 0, 1, 0, 0, 0, 8'hA1};
    tbl[1]  = '{1, 8'hB2, 0, 0, 0, 2, 0, 0, 0, 8'hA1};
    tbl[2]  = '{0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 8'hB2};
    tbl[3]  = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h00};
    tbl[4]  = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 8'h00};
    tbl[5]  = '{1, 8'hC3, 1, 0, 0, 1, 0, 0, 1, 8'hC3};
    tbl[6]  = '{0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 8'hC3};
    tbl[7]  = '{0, 8'h00, 1, 0, 1, 0, 1, 0, 0, 8'h00};
    tbl[8]  = '{0, 8'h00, 1, 0, 1, 0, 1, 0, 1, 8'h00};
    tbl[9]  = '{1, 8'hD4, 0, 1, 0, 0, 1, 0, 1, 8'h00};
    tbl[10] = '{0, 8'h00, 1, 1, 1, 0, 1, 0, 0, 8'h00};
    for (int i = 0; i < 11; i++) begin
      cycle("vec", tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].f, tbl[i].c);
      chk($sformatf("vec%0d.count", i), f_count, tbl[i].ecnt);
      chk($sformatf("vec%0d.empty", i), f_empty, tbl[i].eempty);
      chk($sformatf("vec%0d.ovf", i),   f_ovf,   tbl[i].eovf);
      chk($sformatf("vec%0d.unf", i),   f_unf,   tbl[i].eunf);
      if (!tbl[i].eempty) chk($sformatf("vec%0d.rd", i), f_rd_data, tbl[i].erd);
    end

    // fill and drain
    for (int i = 0; i < 16; i++) begin
      cycle("fill", 1'b1, 8'(i), 1'b0);
      chk("fill.afull", f_af, (i + 1) >= 12);
    end
    chk("fill.full", f_full, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("drain.head", f_rd_data, i);
      cycle("drain", 1'b0, 8'h00, 1'b1);
      chk("drain.reg", r_rd_data, i);
      chk("drain.aempty", f_ae, (15 - i) <= 2);
    end
    chk("drain.empty", f_empty, 1'b1);

    // pointer wrap
    for (int i = 0; i < 10; i++) cycle("wrap.w1", 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) cycle("wrap.r1", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) cycle("wrap.w2", 1'b1, 8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle("wrap.r2", 1'b0, 8'h00, 1'b1);
      chk("wrap.data", r_rd_data, 8'hA0 + 8'(i));
    end
    chk("wrap.errs", {f_ovf, f_unf}, 2'b00);

    // simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) cycle("sim.w", 1'b1, 8'h30 + 8'(i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle("sim.rw", 1'b1, 8'h40 + 8'(i), 1'b1);
      chk("sim.count", f_count, 5);
      chk("sim.data", r_rd_data, (i < 5) ? 8'h30 + 8'(i) : 8'h40 + 8'(i - 5));
    end
    for (int i = 0; i < 5; i++) cycle("sim.r", 1'b0, 8'h00, 1'b1);

    // full + both, empty + both
    for (int i = 0; i < 16; i++) cycle("fb.fill", 1'b1, 8'h60 + 8'(i), 1'b0);
    cycle("fb.both", 1'b1, 8'hEE, 1'b1);
    chk("fb.count", f_count, 15);
    chk("fb.ovf", f_ovf, 1'b1);
    cycle("fb.refill", 1'b1, 8'hEF, 1'b0);
    chk("fb.full", f_full, 1'b1);
    for (int i = 0; i < 16; i++) cycle("fb.drain", 1'b0, 8'h00, 1'b1);
    cycle("eb.both", 1'b1, 8'h77, 1'b1);
    chk("eb.count", f_count, 1);
    chk("eb.unf", f_unf, 1'b1);
    cycle("eb.clr", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // sticky overflow, clr_err, flush keeps errors
    for (int i = 0; i < 16; i++) cycle("ef.fill", 1'b1, 8'(i), 1'b0);
    cycle("ef.ovw", 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) cycle("ef.hold", 1'b0, 8'h00, 1'b0);
    chk("ef.sticky", f_ovf, 1'b1);
    cycle("ef.clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ef.cleared", f_ovf, 1'b0);
    cycle("ef.ovw2", 1'b1, 8'hFE, 1'b0);
    for (int i = 0; i < 7; i++) cycle("ef.r", 1'b0, 8'h00, 1'b1);
    chk("ef.count9", f_count, 9);
    cycle("ef.flush", 1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
    chk("ef.flush_cnt", f_count, 0);
    chk("ef.flush_ovf", f_ovf, 1'b1);
    cycle("ef.clr2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // registered-read latency
    cycle("mode.w", 1'b1, 8'h5A, 1'b0);
    chk("mode.novalid", r_rd_valid, 1'b0);
    cycle("mode.r", 1'b0, 8'h00, 1'b1);
    chk("mode.valid", r_rd_valid, 1'b1);
    chk("mode.data", r_rd_data, 8'h5A);
    cycle("mode.idle", 1'b0, 8'h00, 1'b0);
    chk("mode.pulse", r_rd_valid, 1'b0);
    chk("mode.hold", r_rd_data, 8'h5A);

    // reset in the middle of a write burst
    for (int i = 0; i < 5; i++) cycle("rb.w", 1'b1, 8'h90 + 8'(i), 1'b0);
    do_reset("rb.rst");
    chk("rb.count", f_count, 0);

    // randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 3000; i++) begin
      bit w, r, f, c;
      bit fillish;
      fillish = ((i / 200) % 2) == 0;
      w = $urandom_range(0, 99) < (fillish ? 75 : 30);
      r = $urandom_range(0, 99) < (fillish ? 30 : 75);
      f = $urandom_range(0, 199) == 0;
      c = $urandom_range(0, 39) == 0;
      cycle("rand", w, 8'($urandom), r, f, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
